mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF, read-only) and the memory-access stage (DM, read/write).
- Sequences each access as issue -> fixed-latency wait -> response.
- Returns a one-cycle done pulse with read data to the winner; the core stalls the stage whose req is high and done is low.
- DM has priority; a starvation counter guarantees IF progress.

Parameters:
- XLEN, 32, data/address width
- LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal 1..4
- STARVE_MAX, 4, consecutive contested DM grants before IF is forced through; legal 1..15

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  IF access request; held until if_done
- if_addr  in  XLEN  IF word address
- if_done  out  1  one-cycle pulse; IF access complete
- if_rdata  out  XLEN  IF read data, valid with if_done
- dm_req  in  1  DM access request; held until dm_done
- dm_we  in  1  DM write enable
- dm_addr  in  XLEN  DM address
- dm_wdata  in  XLEN  DM write data
- dm_done  out  1  one-cycle pulse; DM access complete
- dm_rdata  out  XLEN  DM read data, valid with dm_done
- mem_en  out  1  memory command strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data, valid LAT cycles after the mem_en cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE; wait counter and starvation counter clear.
  - All outputs are 0 next cycle.
  - An in-flight access is abandoned with no done pulse; a write already issued may still land in memory.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: sample requests.
  - Neither req: stay in IDLE.
  - Only one req: grant it.
  - Both req: grant DM unless starve_cnt==STARVE_MAX, in which case grant IF.
  - On grant: latch winner ID, addr, we (IF always 0) and wdata; go to ISSUE.
- ISSUE (one cycle): mem_en=1 with latched mem_we/mem_addr/mem_wdata. mem_en is 0 in all other states. Load wait counter with LAT-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At the posedge where counter==0, capture mem_rdata (the cycle ISSUE+LAT) and go to RESP.
  - For LAT=1 WAIT lasts one cycle.
- RESP (one cycle):
  - Winner's done=1 and rdata=captured data. For a write, rdata=0.
  - The loser's done=0 and its rdata holds its last value.
  - Requests are ignored in RESP; go to IDLE.
- Latency: req seen in IDLE at cycle t -> mem_en at t+1 -> done at t+2+LAT.
  - Minimum spacing between back-to-back accesses is LAT+3 cycles.
- Starvation counter (4 bits), updated at grant in IDLE:
  - Contested DM grant: increment, saturating at STARVE_MAX.
  - Any IF grant: clear.
  - Uncontested DM grant: clear.
- Requesters keep req/addr/data stable until done. Changes after the grant have no effect on the access in flight.
- A req dropped before its grant is not serviced and produces no done.
- busy is 0 only in IDLE.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP
  - requester IDs: REQ_IF=0, REQ_DM=1
- Sub-module mem_arb_pick (starvation counter plus grant decision): inputs if_req, dm_req, grant strobe; outputs winner and counter. Everything else is in mem_arbiter.

Test Plan:
- IF read, LAT=1:
  - Stimulus: if_req=1, if_addr=0x40 at cycle 0; memory returns 0xDEADBEEF at cycle 2.
  - Expected: mem_en=1, mem_addr=0x40, mem_we=0 at cycle 1; if_done=1, if_rdata=0xDEADBEEF at cycle 3; dm_done stays 0.
- DM write, LAT=1:
  - Stimulus: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0x12345678 at cycle 0.
  - Expected: mem_en=mem_we=1 with that addr/data at cycle 1; dm_done=1, dm_rdata=0 at cycle 3; busy high during cycles 1-3.
- Simultaneous requests:
  - Stimulus: if_req and dm_req both high from cycle 0.
  - Expected: DM issued at cycle 1, dm_done at cycle 3; IF issued at cycle 5, if_done at cycle 7.
- Starvation, STARVE_MAX=2:
  - Stimulus: if_req held high; dm_req re-raised immediately after every dm_done.
  - Expected: grant order DM, DM, IF, DM, DM, IF.
- Reset mid-access:
  - Stimulus: reset=0 for one cycle while in WAIT with LAT=3.
  - Expected: next cycle mem_en=0, busy=0, no done pulse; with if_req still high after release, a fresh mem_en follows one cycle later.
- LAT=3 read:
  - Stimulus: dm_req read at cycle 0.
  - Expected: mem_en at cycle 1; mem_rdata sampled at cycle 4; dm_done at cycle 5.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, requester IDs and counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Requester IDs
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  // Starvation counter width (STARVE_MAX up to 15)
  localparam int CNT_W  = 4;
  // Wait counter width (holds LAT-1 for LAT up to 4)
  localparam int WAIT_W = 2;

  // Value loaded into the wait counter when leaving ISSUE
  function automatic logic [WAIT_W-1:0] wait_load(input int lat);
    return WAIT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IF/DM request ports plus the single-port memory command/data bus.
// Latency: n/a (wiring only).
// Backpressure: req held high until matching done; no other flow control.
interface mem_arbiter_if #(parameter int XLEN = 32);

  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_done;
  logic [XLEN-1:0] if_rdata;

  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_done;
  logic [XLEN-1:0] dm_rdata;

  logic            mem_en;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  logic            busy;

  // Pipeline stages and memory model side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_done, if_rdata, dm_done, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_done, if_rdata, dm_done, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant decision (DM first) with saturating starvation counter protecting IF.
// Latency: winner is combinational from reqs/counter; counter updates on the grant edge.
// Backpressure: none; the caller only strobes grant when it can accept an access.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic             dm_req,
  input  logic             grant,
  output logic             winner,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic contested;

  // Pick DM unless both ask and IF has already lost STARVE_MAX times in a row
  always_comb begin
    contested = if_req & dm_req;
    winner    = REQ_IF;
    if (contested) begin
      winner = (starve_cnt == CNT_MAX) ? REQ_IF : REQ_DM;
    end else if (dm_req) begin
      winner = REQ_DM;
    end
  end

  // Count consecutive contested DM wins; any other grant restarts the count
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (contested && (winner == REQ_DM)) begin
        starve_cnt <= (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port fixed-latency memory between IF (read) and DM (read/write).
// Latency: req seen in IDLE at t -> mem_en at t+1 -> done at t+2+LAT; back-to-back spacing LAT+3.
// Backpressure: requesters hold req until their done pulse; the losing stage simply stalls.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              win, win_nxt;
  logic              acc_we, acc_we_nxt;

  logic              mem_en_r, mem_en_nxt;
  logic              mem_we_r, mem_we_nxt;
  logic [XLEN-1:0]   mem_addr_r, mem_addr_nxt;
  logic [XLEN-1:0]   mem_wdata_r, mem_wdata_nxt;
  logic              if_done_r, if_done_nxt;
  logic [XLEN-1:0]   if_rdata_r, if_rdata_nxt;
  logic              dm_done_r, dm_done_nxt;
  logic [XLEN-1:0]   dm_rdata_r, dm_rdata_nxt;
  logic              busy_r, busy_nxt;

  logic              grant;
  logic              pick_winner;
  logic [XLEN-1:0]   resp_data;
  // Counter lives in the pick block; exposed here only as a debug probe point
  logic [CNT_W-1:0]  dbg_starve_cnt_unused;

  assign grant = (state == ST_IDLE) && (bus.if_req || bus.dm_req);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk        (clk),
    .reset      (reset),
    .if_req     (bus.if_req),
    .dm_req     (bus.dm_req),
    .grant      (grant),
    .winner     (pick_winner),
    .starve_cnt (dbg_starve_cnt_unused)
  );

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    win_nxt       = win;
    acc_we_nxt    = acc_we;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr_r;
    mem_wdata_nxt = mem_wdata_r;
    if_done_nxt   = 1'b0;
    if_rdata_nxt  = if_rdata_r;
    dm_done_nxt   = 1'b0;
    dm_rdata_nxt  = dm_rdata_r;
    resp_data     = '0;

    case (state)
      ST_IDLE: begin
        if (grant) begin
          state_nxt = ST_ISSUE;
          win_nxt   = pick_winner;
          if (pick_winner == REQ_DM) begin
            acc_we_nxt    = bus.dm_we;
            mem_addr_nxt  = bus.dm_addr;
            mem_wdata_nxt = bus.dm_wdata;
          end else begin
            acc_we_nxt    = 1'b0;
            mem_addr_nxt  = bus.if_addr;
            mem_wdata_nxt = '0;
          end
          mem_en_nxt = 1'b1;
          mem_we_nxt = acc_we_nxt;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
        wait_nxt  = wait_load(LAT);
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = ST_RESP;
          // Writes return zero rather than whatever the memory drives
          resp_data = acc_we ? '0 : bus.mem_rdata;
          if (win == REQ_DM) begin
            dm_done_nxt  = 1'b1;
            dm_rdata_nxt = resp_data;
          end else begin
            if_done_nxt  = 1'b1;
            if_rdata_nxt = resp_data;
          end
        end else begin
          wait_nxt = wait_cnt - WAIT_W'(1);
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      win         <= REQ_IF;
      acc_we      <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_done_r   <= 1'b0;
      if_rdata_r  <= '0;
      dm_done_r   <= 1'b0;
      dm_rdata_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      win         <= win_nxt;
      acc_we      <= acc_we_nxt;
      mem_en_r    <= mem_en_nxt;
      mem_we_r    <= mem_we_nxt;
      mem_addr_r  <= mem_addr_nxt;
      mem_wdata_r <= mem_wdata_nxt;
      if_done_r   <= if_done_nxt;
      if_rdata_r  <= if_rdata_nxt;
      dm_done_r   <= dm_done_nxt;
      dm_rdata_r  <= dm_rdata_nxt;
      busy_r      <= busy_nxt;
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_done   = if_done_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.dm_done   = dm_done_r;
  assign bus.dm_rdata  = dm_rdata_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle vectors on a LAT=1 arbiter plus multi-cycle sequences on LAT=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

  localparam logic [31:0] G  = 32'hBAD0BAD0;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] W  = 32'h12345678;
  localparam logic [31:0] D2 = 32'h55AA55AA;
  localparam logic [31:0] CF = 32'hCAFEF00D;
  localparam logic [31:0] R2 = 32'h13579BDF;
  localparam int NV = 17;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;

  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(32)) b1();
  mem_arbiter_if #(.XLEN(32)) b3();

  mem_arbiter #(.XLEN(32), .LAT(1), .STARVE_MAX(2)) dut1 (.clk(clk), .reset(rst1), .bus(b1));
  mem_arbiter #(.XLEN(32), .LAT(3), .STARVE_MAX(4)) dut3 (.clk(clk), .reset(rst3), .bus(b3));

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [31:0] mr;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_idone;
    logic [31:0] e_irdata;
    logic        e_ddone;
    logic [31:0] e_drdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs[NV];
  int   exp_who[6];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
    input logic [31:0] mr,
    input logic e_en, input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input logic e_idone, input logic [31:0] e_irdata,
    input logic e_ddone, input logic [31:0] e_drdata, input logic e_busy);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.mr = mr;
    v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_idone = e_idone; v.e_irdata = e_irdata;
    v.e_ddone = e_ddone; v.e_drdata = e_drdata; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk_all(input string tag, input logic en, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic idone, input logic [31:0] irdata,
                         input logic ddone, input logic [31:0] drdata, input logic bsy);
    chk({tag, " mem_en"},    32'(b1.mem_en),  32'(en));
    chk({tag, " mem_we"},    32'(b1.mem_we),  32'(we));
    chk({tag, " mem_addr"},  b1.mem_addr,     addr);
    chk({tag, " mem_wdata"}, b1.mem_wdata,    wdata);
    chk({tag, " if_done"},   32'(b1.if_done), 32'(idone));
    chk({tag, " if_rdata"},  b1.if_rdata,     irdata);
    chk({tag, " dm_done"},   32'(b1.dm_done), 32'(ddone));
    chk({tag, " dm_rdata"},  b1.dm_rdata,     drdata);
    chk({tag, " busy"},      32'(b1.busy),    32'(bsy));
  endtask

  // Watchdog: the run must never hang
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  t;
    bit  got;
    int  who;

    exp_who = '{1, 1, 0, 1, 1, 0};

    // Columns: ir ia | dr dw da dd | mem_rdata || en we addr wdata | idone irdata | ddone drdata | busy
    vecs[0]  = mk(1'b1, 32'h40, 1'b0, 1'b0, 0, 0, G,  1'b0, 1'b0, 0,      0,  1'b0, 0,  1'b0, 0,  1'b0);
    vecs[1]  = mk(1'b1, 32'h40, 1'b0, 1'b0, 0, 0, G,  1'b1, 1'b0, 32'h40, 0,  1'b0, 0,  1'b0, 0,  1'b1);
    vecs[2]  = mk(1'b1, 32'h40, 1'b0, 1'b0, 0, 0, DB, 1'b0, 1'b0, 32'h40, 0,  1'b0, 0,  1'b0, 0,  1'b1);
    vecs[3]  = mk(1'b0, 0,      1'b0, 1'b0, 0, 0, G,  1'b0, 1'b0, 32'h40, 0,  1'b1, DB, 1'b0, 0,  1'b1);
    vecs[4]  = mk(1'b0, 0,      1'b1, 1'b1, 32'h100, W, G, 1'b0, 1'b0, 32'h40,  0, 1'b0, DB, 1'b0, 0, 1'b0);
    vecs[5]  = mk(1'b0, 0,      1'b1, 1'b1, 32'h100, W, G, 1'b1, 1'b1, 32'h100, W, 1'b0, DB, 1'b0, 0, 1'b1);
    vecs[6]  = mk(1'b0, 0,      1'b1, 1'b1, 32'h100, W, G, 1'b0, 1'b0, 32'h100, W, 1'b0, DB, 1'b0, 0, 1'b1);
    vecs[7]  = mk(1'b0, 0,      1'b0, 1'b0, 0, 0, G,  1'b0, 1'b0, 32'h100, W, 1'b0, DB, 1'b1, 0, 1'b1);
    vecs[8]  = mk(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, D2, G,  1'b0, 1'b0, 32'h100, W,  1'b0, DB, 1'b0, 0,  1'b0);
    vecs[9]  = mk(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, D2, G,  1'b1, 1'b0, 32'h200, D2, 1'b0, DB, 1'b0, 0,  1'b1);
    vecs[10] = mk(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, D2, CF, 1'b0, 1'b0, 32'h200, D2, 1'b0, DB, 1'b0, 0,  1'b1);
    vecs[11] = mk(1'b1, 32'h80, 1'b0, 1'b0, 0, 0, G,  1'b0, 1'b0, 32'h200, D2, 1'b0, DB, 1'b1, CF, 1'b1);
    vecs[12] = mk(1'b1, 32'h80, 1'b0, 1'b0, 0, 0, G,  1'b0, 1'b0, 32'h200, D2, 1'b0, DB, 1'b0, CF, 1'b0);
    vecs[13] = mk(1'b1, 32'h80, 1'b0, 1'b0, 0, 0, G,  1'b1, 1'b0, 32'h80,  0,  1'b0, DB, 1'b0, CF, 1'b1);
    vecs[14] = mk(1'b1, 32'h80, 1'b0, 1'b0, 0, 0, R2, 1'b0, 1'b0, 32'h80,  0,  1'b0, DB, 1'b0, CF, 1'b1);
    vecs[15] = mk(1'b0, 0,      1'b0, 1'b0, 0, 0, G,  1'b0, 1'b0, 32'h80,  0,  1'b1, R2, 1'b0, CF, 1'b1);
    vecs[16] = mk(1'b0, 0,      1'b0, 1'b0, 0, 0, G,  1'b0, 1'b0, 32'h80,  0,  1'b0, R2, 1'b0, CF, 1'b0);

    rst1 = 1'b0; rst3 = 1'b0;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    b1.dm_addr = '0; b1.dm_wdata = '0; b1.mem_rdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.dm_req = 1'b0; b3.dm_we = 1'b0;
    b3.dm_addr = '0; b3.dm_wdata = '0; b3.mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("reset b3 mem_en", 32'(b3.mem_en), 0);
    chk("reset b3 busy",   32'(b3.busy),   0);
    chk("reset b3 rdata",  b3.dm_rdata,    0);
    rst1 = 1'b1; rst3 = 1'b1;

    // Cycle-by-cycle vectors: IF read, DM write, simultaneous requests
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      b1.if_req = vecs[k].ir; b1.if_addr = vecs[k].ia;
      b1.dm_req = vecs[k].dr; b1.dm_we = vecs[k].dw;
      b1.dm_addr = vecs[k].da; b1.dm_wdata = vecs[k].dd;
      b1.mem_rdata = vecs[k].mr;
      @(negedge clk);
      chk_all($sformatf("vec%0d", k), vecs[k].e_en, vecs[k].e_we, vecs[k].e_addr, vecs[k].e_wdata,
              vecs[k].e_idone, vecs[k].e_irdata, vecs[k].e_ddone, vecs[k].e_drdata, vecs[k].e_busy);
    end

    // Starvation with STARVE_MAX=2: IF held, DM re-raised right after each dm_done
    @(negedge clk);
    b1.if_req = 1'b1; b1.if_addr = 32'h500;
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h600; b1.mem_rdata = G;
    for (int g = 0; g < 6; g++) begin
      t = 0; got = 1'b0; who = 2;
      while (!got && t < 20) begin
        @(negedge clk);
        t++;
        if (b1.dm_done && b1.if_done) begin
          who = 3; got = 1'b1;
        end else if (b1.dm_done) begin
          who = 1; got = 1'b1;
          b1.dm_req = 1'b0;
          @(posedge clk); #1;
          b1.dm_req = 1'b1;
        end else if (b1.if_done) begin
          who = 0; got = 1'b1;
        end
      end
      chk($sformatf("starve grant%0d (1=DM 0=IF 2=timeout)", g), 32'(who), 32'(exp_who[g]));
    end
    @(negedge clk);
    b1.if_req = 1'b0; b1.dm_req = 1'b0;

    // LAT=3 DM read: mem_en at c1, data sampled at c4, dm_done at c5
    @(negedge clk);
    b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 32'h400; b3.dm_wdata = '0; b3.mem_rdata = G;
    @(negedge clk);
    chk("lat3 c1 mem_en",   32'(b3.mem_en), 1);
    chk("lat3 c1 mem_addr", b3.mem_addr,    32'h400);
    chk("lat3 c1 mem_we",   32'(b3.mem_we), 0);
    @(negedge clk);
    chk("lat3 c2 mem_en",   32'(b3.mem_en), 0);
    chk("lat3 c2 busy",     32'(b3.busy),   1);
    @(negedge clk);
    chk("lat3 c3 dm_done",  32'(b3.dm_done), 0);
    @(negedge clk);
    chk("lat3 c4 dm_done",  32'(b3.dm_done), 0);
    b3.mem_rdata = 32'hA5A51234;
    @(negedge clk);
    b3.mem_rdata = G;
    chk("lat3 c5 dm_done",  32'(b3.dm_done), 1);
    chk("lat3 c5 dm_rdata", b3.dm_rdata,     32'hA5A51234);
    chk("lat3 c5 if_done",  32'(b3.if_done), 0);
    b3.dm_req = 1'b0;
    @(negedge clk);
    chk("lat3 c6 busy",     32'(b3.busy),    0);
    chk("lat3 c6 dm_done",  32'(b3.dm_done), 0);

    // Reset while in WAIT (LAT=3): access abandoned, IF restarts cleanly
    @(negedge clk);
    b3.if_req = 1'b1; b3.if_addr = 32'h300;
    @(negedge clk);
    chk("rst c1 mem_en", 32'(b3.mem_en), 1);
    @(negedge clk);
    rst3 = 1'b0;
    @(negedge clk);
    chk("rst c3 mem_en",   32'(b3.mem_en),  0);
    chk("rst c3 busy",     32'(b3.busy),    0);
    chk("rst c3 if_done",  32'(b3.if_done), 0);
    chk("rst c3 mem_addr", b3.mem_addr,     0);
    chk("rst c3 dm_rdata", b3.dm_rdata,     0);
    rst3 = 1'b1;
    @(negedge clk);
    chk("rst c4 mem_en",   32'(b3.mem_en), 1);
    chk("rst c4 mem_addr", b3.mem_addr,    32'h300);
    chk("rst c4 busy",     32'(b3.busy),   1);
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("rst c%0d if_done", c), 32'(b3.if_done), 0);
      if (c == 7) b3.mem_rdata = 32'h77778888;
    end
    @(negedge clk);
    b3.mem_rdata = G;
    chk("rst c8 if_done",  32'(b3.if_done), 1);
    chk("rst c8 if_rdata", b3.if_rdata,     32'h77778888);
    b3.if_req = 1'b0;
    @(negedge clk);
    chk("rst c9 busy", 32'(b3.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
